// File: rtl/riscv_pipe_ctrl.sv
// Pipeline sequencer: turns hazard, redirect, trap, MUL/DIV and data-memory wait
// conditions into per-register hold (stall) and bubble (flush) controls.
// It also counts stalled cycles (saturating) and releases a hung MDU with a watchdog.
module riscv_pipe_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_WIDTH   = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 hzd_stall_i,
  input  logic                 redirect_i,
  input  logic                 trap_i,
  input  logic                 mdu_start_i,
  input  logic                 mdu_done_i,
  input  logic                 lsu_req_i,
  input  logic                 lsu_ack_i,
  output logic                 stall_pc_o,
  output logic                 stall_if2id_o,
  output logic                 stall_id2ex_o,
  output logic                 stall_ex2mem_o,
  output logic                 flush_if2id_o,
  output logic                 flush_id2ex_o,
  output logic                 flush_ex2mem_o,
  output logic                 flush_mem2wb_o,
  output logic [1:0]           state_o,
  output logic                 mdu_timeout_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o
);

  localparam int unsigned TimerW = (MDU_TIMEOUT > 2) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(MDU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLsuWait = 2'd1,
    StMduWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [TimerW-1:0]    timer_q, timer_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  // State register, MDU watchdog timer and stall counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StRun;
      timer_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next-state and Mealy stall/flush decode; a flushed register is never also held.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    stall_pc_o     = 1'b0;
    stall_if2id_o  = 1'b0;
    stall_id2ex_o  = 1'b0;
    stall_ex2mem_o = 1'b0;
    flush_if2id_o  = 1'b0;
    flush_id2ex_o  = 1'b0;
    flush_ex2mem_o = 1'b0;
    flush_mem2wb_o = 1'b0;
    mdu_timeout_o  = 1'b0;

    unique case (state_q)
      StRun: begin
        if (trap_i) begin
          flush_if2id_o  = 1'b1;
          flush_id2ex_o  = 1'b1;
          flush_ex2mem_o = 1'b1;
          state_d        = StFlush;
        end else if (lsu_req_i && !lsu_ack_i) begin
          stall_pc_o     = 1'b1;
          stall_if2id_o  = 1'b1;
          stall_id2ex_o  = 1'b1;
          stall_ex2mem_o = 1'b1;
          flush_mem2wb_o = 1'b1;
          state_d        = StLsuWait;
        end else if (mdu_start_i && !mdu_done_i) begin
          stall_pc_o     = 1'b1;
          stall_if2id_o  = 1'b1;
          stall_id2ex_o  = 1'b1;
          flush_ex2mem_o = 1'b1;
          timer_d        = '0;
          state_d        = StMduWait;
        end else if (mdu_start_i && mdu_done_i) begin
          // Single-cycle MDU result: nothing to hold.
        end else if (redirect_i) begin
          flush_if2id_o = 1'b1;
          flush_id2ex_o = 1'b1;
        end else if (hzd_stall_i) begin
          stall_pc_o    = 1'b1;
          stall_if2id_o = 1'b1;
          flush_id2ex_o = 1'b1;
        end
      end
      StLsuWait: begin
        if (lsu_ack_i) begin
          state_d = StRun;
        end else begin
          stall_pc_o     = 1'b1;
          stall_if2id_o  = 1'b1;
          stall_id2ex_o  = 1'b1;
          stall_ex2mem_o = 1'b1;
          flush_mem2wb_o = 1'b1;
        end
      end
      StMduWait: begin
        if (mdu_done_i) begin
          state_d = StRun;
        end else if (timer_q == TimerLast) begin
          // Watchdog release: drop the hold so the pipeline can make progress.
          mdu_timeout_o = 1'b1;
          state_d       = StRun;
        end else begin
          stall_pc_o     = 1'b1;
          stall_if2id_o  = 1'b1;
          stall_id2ex_o  = 1'b1;
          flush_ex2mem_o = 1'b1;
          timer_d        = timer_q + TimerW'(1);
        end
      end
      StFlush: begin
        flush_if2id_o = 1'b1;
        state_d       = StRun;
      end
      default: state_d = StRun;
    endcase

    // Controls must stay quiet while reset is held, even though state already reads RUN.
    if (!rst_ni) begin
      stall_pc_o     = 1'b0;
      stall_if2id_o  = 1'b0;
      stall_id2ex_o  = 1'b0;
      stall_ex2mem_o = 1'b0;
      flush_if2id_o  = 1'b0;
      flush_id2ex_o  = 1'b0;
      flush_ex2mem_o = 1'b0;
      flush_mem2wb_o = 1'b0;
      mdu_timeout_o  = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign state_o     = state_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule
